// File: rtl/fft_frame_serializer_if.sv
// Stream bundle for fft_frame_serializer: parallel frame in, one bin per beat out.
// A complex word is packed as {re[W-1:0], im[W-1:0]}.
interface fft_frame_serializer_if #(
    parameter int N     = 32,
    parameter int W     = 16,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0][2*W-1:0] in_frame;
    logic                  in_valid;

    // A beat moves on a cycle where out_valid && out_ready; once out_valid is
    // raised, out_data/out_index/out_last hold until that beat is taken.
    logic [2*W-1:0]        out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_W-1:0]      out_index;
    logic                  out_last;

    modport master (
        input  in_frame,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_index,
        output out_last
    );

    modport slave (
        output in_frame,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/fft_frame_serializer.sv
// Captures parallel FFT frames into a ping-pong buffer and streams them out one
// bin per beat, with optional DC-centred read order and dropped-frame reporting.
module fft_frame_serializer #(
    parameter int N         = 32,
    parameter bit FFT_SHIFT = 1'b0,
    parameter int W         = 16,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         reset,
    fft_frame_serializer_if.master       bus,
    output logic                         drop_pulse,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [15:0]                  frame_count
);
    localparam int                DW   = 2 * W;
    localparam logic [IDX_W-1:0]  HALF = IDX_W'(N / 2);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(N - 1);

    logic [N-1:0][DW-1:0] mem [2];

    logic [1:0]       full, full_n;
    logic             wr_bank, wr_bank_n;
    logic             rd_bank, rd_bank_n;
    logic [IDX_W-1:0] rd_cnt, rd_cnt_n;
    logic [15:0]      frame_count_n;
    logic             overflow_n;

    logic             valid;
    logic             last;
    logic             xfer;
    logic             free_evt;
    logic             accept;
    logic             reject;
    logic [IDX_W-1:0] phys;

    always_comb begin
        valid    = full[rd_bank];
        last     = valid && (rd_cnt == LAST);
        xfer     = valid && bus.out_ready;
        free_evt = xfer && last;
        // When both banks are full the write bank equals the read bank, so a
        // frame arriving on the final beat can reuse the bank being released.
        accept   = bus.in_valid && (!full[wr_bank] || (free_evt && (wr_bank == rd_bank)));
        reject   = bus.in_valid && !accept;
    end

    always_comb begin
        full_n        = full;
        wr_bank_n     = wr_bank;
        rd_bank_n     = rd_bank;
        rd_cnt_n      = rd_cnt;
        frame_count_n = frame_count;
        overflow_n    = overflow;

        if (xfer) begin
            if (last) begin
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = ~rd_bank;
                rd_cnt_n        = '0;
                frame_count_n   = frame_count + 16'd1;
            end else begin
                rd_cnt_n = rd_cnt + 1'b1;
            end
        end

        if (accept) begin
            full_n[wr_bank] = 1'b1;
            wr_bank_n       = ~wr_bank;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (reject) begin
            overflow_n = 1'b1;
        end else if (clear_overflow) begin
            overflow_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            frame_count <= 16'd0;
            overflow    <= 1'b0;
            drop_pulse  <= 1'b0;
        end else begin
            full        <= full_n;
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            rd_cnt      <= rd_cnt_n;
            frame_count <= frame_count_n;
            overflow    <= overflow_n;
            drop_pulse  <= reject;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank] <= bus.in_frame;
        end
    end

    // Shifted order wraps naturally because N is a power of two.
    always_comb begin
        phys          = FFT_SHIFT ? (rd_cnt + HALF) : rd_cnt;
        bus.out_valid = valid;
        bus.out_last  = last;
        bus.out_index = valid ? phys : '0;
        bus.out_data  = valid ? mem[rd_bank][phys] : '0;
    end
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: natural and shifted instances share stimulus and
// are checked against a frame-queue reference model, a beat scoreboard and a vector table.
module tb_fft_frame_serializer;
    localparam int N     = 8;
    localparam int W     = 16;
    localparam int DW    = 2 * W;
    localparam int IDX_W = $clog2(N);

    typedef logic [N-1:0][DW-1:0] frame_t;

    typedef struct {
        logic             in_valid;
        logic             out_ready;
        logic             exp_valid;
        logic [IDX_W-1:0] exp_idx0;
        logic [IDX_W-1:0] exp_idx1;
        logic             exp_last;
        logic [15:0]      exp_fc;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_t in_frame;
    logic   in_valid;
    logic   out_ready;
    logic   clr;
    logic   drop0, drop1, ovf0, ovf1;
    logic [15:0] fc0, fc1;

    fft_frame_serializer_if #(.N(N), .W(W)) bus0 ();
    fft_frame_serializer_if #(.N(N), .W(W)) bus1 ();

    assign bus0.in_frame  = in_frame;
    assign bus0.in_valid  = in_valid;
    assign bus0.out_ready = out_ready;
    assign bus1.in_frame  = in_frame;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;

    fft_frame_serializer #(.N(N), .FFT_SHIFT(1'b0), .W(W)) u_nat (
        .clk(clk), .reset(reset), .bus(bus0),
        .drop_pulse(drop0), .overflow(ovf0), .clear_overflow(clr), .frame_count(fc0)
    );

    fft_frame_serializer #(.N(N), .FFT_SHIFT(1'b1), .W(W)) u_shf (
        .clk(clk), .reset(reset), .bus(bus1),
        .drop_pulse(drop1), .overflow(ovf1), .clear_overflow(clr), .frame_count(fc1)
    );

    // ---------------- reference model + scoreboard ----------------
    frame_t          fq[$];      // frames held, head is being streamed
    int              pos;        // beats of the head frame already delivered
    logic [15:0]     m_fc;
    logic            m_ovf;
    logic            m_drop;
    logic [DW-1:0]   exp_q[$];   // natural-order beats expected from u_nat
    int              tests = 0;
    int              fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        exp_q.delete();
        pos    = 0;
        m_fc   = 16'd0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
    endtask

    // A frame fits if fewer than two are held, or the head finishes on this edge.
    task automatic model_update(input logic v, input frame_t f, input logic rdy, input logic c);
        logic have, xfer, done, acc;
        have = fq.size() > 0;
        xfer = have && rdy;
        done = xfer && (pos == N - 1);
        acc  = v && ((fq.size() < 2) || done);
        if (xfer) begin
            if (done) begin
                void'(fq.pop_front());
                pos  = 0;
                m_fc = m_fc + 16'd1;
            end else begin
                pos++;
            end
        end
        if (acc) begin
            fq.push_back(f);
            for (int k = 0; k < N; k++) exp_q.push_back(f[k]);
        end
        m_drop = v && !acc;
        if (m_drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic check_dut(input string tag, input bit s, input logic v,
                             input logic [IDX_W-1:0] idx, input logic [DW-1:0] d,
                             input logic l, input logic dr, input logic ov,
                             input logic [15:0] fc);
        logic          mv;
        int            p;
        logic [DW-1:0] ed;
        mv = fq.size() > 0;
        p  = s ? (pos + N / 2) % N : pos;
        ed = mv ? fq[0][p] : '0;
        chk({tag, "_valid"}, 32'(v), 32'(mv));
        chk({tag, "_index"}, 32'(idx), mv ? 32'(p) : 32'd0);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_last"}, 32'(l), 32'(mv && (pos == N - 1)));
        chk({tag, "_drop"}, 32'(dr), 32'(m_drop));
        chk({tag, "_overflow"}, 32'(ov), 32'(m_ovf));
        chk({tag, "_frame_count"}, 32'(fc), 32'(m_fc));
    endtask

    task automatic check_both();
        check_dut("nat", 1'b0, bus0.out_valid, bus0.out_index, bus0.out_data,
                  bus0.out_last, drop0, ovf0, fc0);
        check_dut("shf", 1'b1, bus1.out_valid, bus1.out_index, bus1.out_data,
                  bus1.out_last, drop1, ovf1, fc1);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive, clock, update model, check at next negedge.
    task automatic cycle(input logic v, input frame_t f, input logic rdy, input logic c);
        in_valid  = v;
        in_frame  = f;
        out_ready = rdy;
        clr       = c;
        if (bus0.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: beat %0h with nothing expected at %0t", bus0.out_data, $time);
            end else begin
                chk("sb_data", bus0.out_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        model_update(v, f, rdy, c);
        @(negedge clk);
        check_both();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        reset     = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_both();
    endtask

    function automatic frame_t ramp_frame(input int base);
        frame_t f;
        for (int k = 0; k < N; k++) f[k] = {16'(base + k), 16'(-(base + k))};
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < N; k++) f[k] = $urandom;
        return f;
    endfunction

    // ---------------- test sequence ----------------
    vec_t   tv[10];
    frame_t fa, fb, fc_frm;
    int     gaps, drops, hit;

    initial begin
        in_frame = '0;
        do_reset();

        // Single ramp frame, ready high: both read orders, last beat, count.
        for (int r = 0; r < 10; r++) begin
            tv[r].in_valid  = (r == 0);
            tv[r].out_ready = 1'b1;
            tv[r].exp_valid = (r < N);
            tv[r].exp_idx0  = (r < N) ? IDX_W'(r) : '0;
            tv[r].exp_idx1  = (r < N) ? IDX_W'((r + N / 2) % N) : '0;
            tv[r].exp_last  = (r == N - 1);
            tv[r].exp_fc    = (r >= N) ? 16'd1 : 16'd0;
        end
        fa = ramp_frame(0);
        for (int r = 0; r < 10; r++) begin
            cycle(tv[r].in_valid, fa, tv[r].out_ready, 1'b0);
            chk("tv_valid", 32'(bus0.out_valid), 32'(tv[r].exp_valid));
            chk("tv_idx_nat", 32'(bus0.out_index), 32'(tv[r].exp_idx0));
            chk("tv_idx_shf", 32'(bus1.out_index), 32'(tv[r].exp_idx1));
            chk("tv_last_nat", 32'(bus0.out_last), 32'(tv[r].exp_last));
            chk("tv_last_shf", 32'(bus1.out_last), 32'(tv[r].exp_last));
            chk("tv_fc", 32'(fc0), 32'(tv[r].exp_fc));
            if (tv[r].exp_valid)
                chk("tv_data_shf", bus1.out_data, fa[tv[r].exp_idx1]);
        end

        // Back-to-back frames N cycles apart: no bubble, no drop.
        fa = ramp_frame(16);
        fb = ramp_frame(32);
        gaps  = 0;
        drops = 0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            cycle(i == 0 || i == N, (i == 0) ? fa : fb, 1'b1, 1'b0);
            if (i < 2 * N && !bus0.out_valid) gaps++;
            if (drop0) drops++;
        end
        chk("b2b_gaps", 32'(gaps), 32'd0);
        chk("b2b_drops", 32'(drops), 32'd0);

        // Stalled consumer, three frames: third dropped, then drain and clear.
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(i % 2 == 0, ramp_frame(64 + 8 * i), 1'b0, 1'b0);
            if (drop0) drops++;
        end
        chk("ovf_drop_count", 32'(drops), 32'd1);
        chk("ovf_sticky", 32'(ovf0), 32'd1);
        for (int i = 0; i < 2 * N + 2; i++) cycle(1'b0, fa, 1'b1, 1'b0);
        chk("ovf_held", 32'(ovf0), 32'd1);
        cycle(1'b0, fa, 1'b1, 1'b1);
        chk("ovf_cleared", 32'(ovf0), 32'd0);

        // Third frame arriving on the last beat of the head frame is kept.
        fa     = ramp_frame(100);
        fb     = ramp_frame(120);
        fc_frm = ramp_frame(140);
        cycle(1'b1, fa, 1'b0, 1'b0);
        cycle(1'b0, fa, 1'b0, 1'b0);
        cycle(1'b1, fb, 1'b0, 1'b0);
        hit = 0;
        for (int i = 0; i < 3 * N && hit == 0; i++) begin
            if (fq.size() == 2 && pos == N - 1) begin
                cycle(1'b1, fc_frm, 1'b1, 1'b0);
                hit = 1;
                chk("coincide_no_drop", 32'(drop0), 32'd0);
            end else begin
                cycle(1'b0, fc_frm, 1'b1, 1'b0);
            end
        end
        chk("coincide_reached", 32'(hit), 32'd1);
        for (int i = 0; i < N; i++) cycle(1'b0, fa, 1'b1, 1'b0);
        chk("coincide_c_bin0", bus0.out_data, fc_frm[0]);
        for (int i = 0; i < N + 2; i++) cycle(1'b0, fa, 1'b1, 1'b0);
        chk("coincide_ovf", 32'(ovf0), 32'd0);

        // Asynchronous reset in the middle of a frame.
        fa = ramp_frame(200);
        for (int i = 0; i < 4; i++) cycle(i == 0, fa, 1'b1, 1'b0);
        chk("pre_reset_idx", 32'(bus0.out_index), 32'd3);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus0.out_valid), 32'd0);
        chk("async_rst_fc", 32'(fc0), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_both();
        fa = ramp_frame(300);
        cycle(1'b1, fa, 1'b1, 1'b0);
        chk("post_rst_idx", 32'(bus0.out_index), 32'd0);
        for (int i = 0; i < N + 1; i++) cycle(1'b0, fa, 1'b1, 1'b0);

        // Random traffic, back-pressure and clears against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 5) == 0, rand_frame(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 3 * N; i++) cycle(1'b0, fa, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
